// File: rtl/dma_req_arbiter.sv
// rtl/dma_req_arbiter.sv - N-channel DMA request arbiter with HRQ/HLDA hold handshake
module dma_req_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int DREQ_ACT_HIGH = 1,
  parameter int DACK_ACT_HIGH = 0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic [NUM_CH-1:0]         mask_i,
  input  logic [NUM_CH-1:0]         sw_req_set_i,
  input  logic                      rotate_i,
  input  logic                      HLDA,
  input  logic                      done_i,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic                      grant_valid_o,
  output logic [$clog2(NUM_CH)-1:0] grant_ch_o,
  output logic [NUM_CH-1:0]         sw_req_o,
  output logic                      hlda_err_o
);

  localparam int CW      = $clog2(NUM_CH);
  localparam int LAST_CH = NUM_CH - 1;

  localparam logic              DREQ_ON   = (DREQ_ACT_HIGH != 0);
  localparam logic              DACK_ON   = (DACK_ACT_HIGH != 0);
  localparam logic [NUM_CH-1:0] DREQ_IDLE = {NUM_CH{~DREQ_ON}};
  localparam logic [NUM_CH-1:0] DACK_IDLE = {NUM_CH{~DACK_ON}};
  localparam logic [CW:0]       CH_COUNT  = NUM_CH[CW:0];
  localparam logic [CW-1:0]     CH_LAST   = LAST_CH[CW-1:0];
  localparam logic [NUM_CH-1:0] ONE_HOT0  = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_REQ = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   dreq_meta_q, dreq_sync_q;
  logic [NUM_CH-1:0]   sw_req_q, sw_req_d;
  logic [CW-1:0]       prio_ptr_q, prio_ptr_d;
  logic [CW-1:0]       grant_ch_q, grant_ch_d;
  logic                grant_valid_q, grant_valid_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_q, dack_d;
  logic                hlda_err_q, hlda_err_d;

  logic [NUM_CH-1:0]   dreq_norm;
  logic [NUM_CH-1:0]   pending;
  logic                any_pending;
  logic [CW-1:0]       eff_ptr;
  logic [2*NUM_CH-1:0] pend_dbl;
  logic [NUM_CH-1:0]   pend_rot;
  logic [CW-1:0]       win_off;
  logic [CW:0]         win_sum;
  logic [CW-1:0]       win_ch;
  logic                done_ok;
  logic [NUM_CH-1:0]   grant_oh_q;
  logic [NUM_CH-1:0]   grant_oh_d;
  logic [CW-1:0]       ptr_after_grant;

  // Two-flop synchroniser on the raw DREQ pins; reset parks it at "not requesting"
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dreq_meta_q <= DREQ_IDLE;
      dreq_sync_q <= DREQ_IDLE;
    end else begin
      dreq_meta_q <= DREQ;
      dreq_sync_q <= dreq_meta_q;
    end
  end

  assign dreq_norm   = DREQ_ON ? dreq_sync_q : ~dreq_sync_q;
  assign pending     = (dreq_norm & ~mask_i) | sw_req_q;
  assign any_pending = |pending;
  assign eff_ptr     = rotate_i ? prio_ptr_q : '0;

  // Winner search: rotate pending so prio_ptr lands at bit 0, take lowest set bit, map back
  always_comb begin
    pend_dbl = {pending, pending} >> eff_ptr;
    pend_rot = pend_dbl[NUM_CH-1:0];
    win_off  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_rot[i]) begin
        win_off = CW'(i);
      end
    end
    win_sum = {1'b0, eff_ptr} + {1'b0, win_off};
    if (win_sum >= CH_COUNT) begin
      win_sum = win_sum - CH_COUNT;
    end
    win_ch = win_sum[CW-1:0];
  end

  // Bus-hold state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a live grant ignores pending/mask changes until done_i or HLDA loss
  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    hlda_err_d = hlda_err_q;
    done_ok    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          state_d = ST_HOLD_REQ;
        end
      end
      ST_HOLD_REQ: begin
        if (HLDA) begin
          if (any_pending) begin
            state_d    = ST_GRANT;
            grant_ch_d = win_ch;
          end else begin
            state_d = ST_RELEASE;
          end
        end else if (!any_pending) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (done_i) begin
          state_d = ST_RELEASE;
          done_ok = 1'b1;
        end else if (!HLDA) begin
          state_d    = ST_IDLE;
          hlda_err_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!HLDA) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign grant_oh_q      = ONE_HOT0 << grant_ch_q;
  assign grant_oh_d      = ONE_HOT0 << grant_ch_d;
  assign ptr_after_grant = (grant_ch_q == CH_LAST) ? '0 : grant_ch_q + 1'b1;

  // Output, software-request and priority-pointer next values, all derived from state_d
  always_comb begin
    grant_valid_d = (state_d == ST_GRANT);
    hrq_d         = (state_d == ST_HOLD_REQ) || (state_d == ST_GRANT);
    dack_d        = DACK_IDLE;
    if (grant_valid_d) begin
      dack_d = DACK_ON ? grant_oh_d : ~grant_oh_d;
    end
    sw_req_d = sw_req_q;
    if (done_ok) begin
      sw_req_d = sw_req_d & ~grant_oh_q;
    end
    sw_req_d   = sw_req_d | sw_req_set_i;
    prio_ptr_d = prio_ptr_q;
    if (!rotate_i) begin
      prio_ptr_d = '0;
    end else if (done_ok) begin
      prio_ptr_d = ptr_after_grant;
    end
  end

  // Registered outputs and arbitration state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_req_q      <= '0;
      prio_ptr_q    <= '0;
      grant_ch_q    <= '0;
      grant_valid_q <= 1'b0;
      hrq_q         <= 1'b0;
      dack_q        <= DACK_IDLE;
      hlda_err_q    <= 1'b0;
    end else begin
      sw_req_q      <= sw_req_d;
      prio_ptr_q    <= prio_ptr_d;
      grant_ch_q    <= grant_ch_d;
      grant_valid_q <= grant_valid_d;
      hrq_q         <= hrq_d;
      dack_q        <= dack_d;
      hlda_err_q    <= hlda_err_d;
    end
  end

  assign HRQ           = hrq_q;
  assign DACK          = dack_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_ch_o    = grant_ch_q;
  assign sw_req_o      = sw_req_q;
  assign hlda_err_o    = hlda_err_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// tb/tb_dma_req_arbiter.sv - scoreboard bench for dma_req_arbiter
module tb_dma_req_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] dreq_v = 4'b0000;
  logic [3:0] mask_v = 4'b0000;
  logic [3:0] swset_v = 4'b0000;
  logic       rot_v = 1'b0;
  logic       HLDA = 1'b0;
  logic       done_v = 1'b0;

  logic       HRQ;
  logic [3:0] DACK;
  logic       grant_valid_o;
  logic [1:0] grant_ch_o;
  logic [3:0] sw_req_o;
  logic       hlda_err_o;

  int         checks = 0;
  int         errors = 0;
  int         exp_q[$];
  int         cur_exp = 0;
  logic       gv_prev = 1'b0;
  logic [3:0] sw_model = 4'b0000;
  int         ptr_m = 0;

  dma_req_arbiter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (dreq_v),
    .mask_i       (mask_v),
    .sw_req_set_i (swset_v),
    .rotate_i     (rot_v),
    .HLDA         (HLDA),
    .done_i       (done_v),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .grant_valid_o(grant_valid_o),
    .grant_ch_o   (grant_ch_o),
    .sw_req_o     (sw_req_o),
    .hlda_err_o   (hlda_err_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Highest-priority requester: first set bit walking p, p+1, ... modulo 4
  function automatic int pick(input logic [3:0] pend, input int p);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (p + i) % 4;
      if (((pend >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  // Monitor: every new grant pops the expected channel; DACK/HRQ checked every cycle
  always @(negedge CLK) begin
    if (grant_valid_o && !gv_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got ch %0d expected no grant", grant_ch_o);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    if (grant_valid_o) begin
      chk("grant_ch", grant_ch_o, cur_exp);
      chk("dack_grant", DACK, 4'b1111 ^ (4'b0001 << cur_exp));
      chk("hrq_in_grant", HRQ, 1);
    end else begin
      chk("dack_idle", DACK, 4'b1111);
    end
    gv_prev = grant_valid_o;
  end

  task automatic wait_hrq(input logic val, input string name);
    for (int k = 0; k < 30 && HRQ !== val; k++) tick();
    chk(name, HRQ, val);
  endtask

  task automatic set_hw(input logic [3:0] d, input logic [3:0] m, input logic [3:0] s, input logic r);
    dreq_v  = d;
    mask_v  = m;
    rot_v   = r;
    swset_v = s;
    sw_model = sw_model | s;
    if (!r) ptr_m = 0;
    tick();
    swset_v = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic model_reset();
    sw_model = 4'b0000;
    ptr_m    = 0;
  endtask

  // mode 0: done; 1: HLDA drop (error); 2: done with HLDA drop; 3: reset mid-grant
  task automatic run_grant(input int pre, input int hold, input int mode, input bit churn);
    int win;
    logic [3:0] pend;
    wait_hrq(1, "hrq_rise");
    repeat (pre) tick();
    pend = (dreq_v & ~mask_v) | sw_model;
    win  = pick(pend, rot_v ? ptr_m : 0);
    exp_q.push_back(win);
    HLDA = 1'b1;
    tick();
    chk("grant_valid_rise", grant_valid_o, 1);
    for (int h = 0; h < hold; h++) begin
      if (churn) begin
        dreq_v = 4'($urandom);
        mask_v = 4'($urandom);
      end
      tick();
    end
    case (mode)
      0, 2: begin
        done_v = 1'b1;
        if (mode == 2) HLDA = 1'b0;
        tick();
        done_v = 1'b0;
        sw_model = sw_model & ~(4'b0001 << win);
        ptr_m = rot_v ? (win + 1) % 4 : 0;
        chk("done_hrq", HRQ, 0);
        chk("done_gv", grant_valid_o, 0);
        chk("done_sw_req", sw_req_o, sw_model);
        chk("done_no_err", hlda_err_o, 0);
        HLDA = 1'b0;
        tick();
        chk("gap_hrq", HRQ, 0);
      end
      1: begin
        HLDA = 1'b0;
        tick();
        chk("err_set", hlda_err_o, 1);
        chk("err_gv", grant_valid_o, 0);
        chk("err_dack", DACK, 4'b1111);
        chk("err_hrq", HRQ, 0);
        tick();
        chk("err_sticky", hlda_err_o, 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        model_reset();
        chk("err_cleared", hlda_err_o, 0);
      end
      default: begin
        RESET = 1'b1;
        HLDA  = 1'b0;
        tick();
        chk("rst_mid_hrq", HRQ, 0);
        chk("rst_mid_gv", grant_valid_o, 0);
        chk("rst_mid_dack", DACK, 4'b1111);
        chk("rst_mid_ch", grant_ch_o, 0);
        chk("rst_mid_sw", sw_req_o, 0);
        RESET = 1'b0;
        model_reset();
      end
    endcase
  endtask

  initial begin
    // Reset held with every request active and HLDA high
    RESET  = 1'b1;
    dreq_v = 4'b1111;
    HLDA   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_hrq", HRQ, 0);
      chk("rst_dack", DACK, 4'b1111);
      chk("rst_gv", grant_valid_o, 0);
      chk("rst_err", hlda_err_o, 0);
      chk("rst_ch", grant_ch_o, 0);
      chk("rst_sw", sw_req_o, 0);
    end
    dreq_v = 4'b0000;
    HLDA   = 1'b0;
    tick();
    RESET = 1'b0;
    repeat (4) tick();
    chk("idle_hrq", HRQ, 0);

    // Fixed priority with DREQ latency of three edges
    dreq_v = 4'b1010;
    tick();
    chk("lat_hw_e0", HRQ, 0);
    tick();
    chk("lat_hw_e1", HRQ, 0);
    tick();
    chk("lat_hw_e2", HRQ, 1);
    run_grant(2, 2, 0, 1'b0);
    dreq_v = 4'b1010;
    run_grant(1, 1, 0, 1'b0);

    // Masked hardware request, then software request overriding the mask
    set_hw(4'b0100, 4'b0100, 4'b0000, 1'b0);
    repeat (3) tick();
    chk("masked_hrq", HRQ, 0);
    swset_v = 4'b0100;
    sw_model = 4'b0100;
    tick();
    swset_v = 4'b0000;
    chk("sw_latch", sw_req_o, 4'b0100);
    chk("lat_sw_e0", HRQ, 0);
    tick();
    chk("lat_sw_e1", HRQ, 1);
    run_grant(0, 2, 0, 1'b0);
    repeat (3) tick();
    chk("sw_cleared_idle", HRQ, 0);

    // Rotating priority with all requests held
    set_hw(4'b1111, 4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) run_grant(i % 2, 1, 0, 1'b0);

    // HLDA withdrawn during GRANT, then simultaneous done/HLDA drop, then reset mid-grant
    set_hw(4'b0011, 4'b0000, 4'b0000, 1'b0);
    run_grant(0, 1, 1, 1'b0);
    set_hw(4'b0011, 4'b0000, 4'b0000, 1'b0);
    run_grant(0, 2, 2, 1'b0);
    set_hw(4'b1000, 4'b0000, 4'b0000, 1'b0);
    run_grant(1, 1, 3, 1'b0);
    dreq_v = 4'b0000;
    repeat (4) tick();

    // Request vanishes in HOLD_REQ without HLDA
    set_hw(4'b0001, 4'b0000, 4'b0000, 1'b0);
    wait_hrq(1, "van1_hrq_up");
    dreq_v = 4'b0000;
    wait_hrq(0, "van1_hrq_down");
    repeat (2) tick();

    // Request vanishes in the same cycle HLDA arrives
    dreq_v = 4'b0001;
    wait_hrq(1, "van2_hrq_up");
    dreq_v = 4'b0000;
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    chk("van2_release_hrq", HRQ, 0);
    chk("van2_release_gv", grant_valid_o, 0);
    tick();
    chk("van2_release_hold", HRQ, 0);
    HLDA = 1'b0;
    repeat (2) tick();
    chk("van2_idle", HRQ, 0);

    // Randomized services
    for (int it = 0; it < 40; it++) begin
      logic [3:0] d, m, s;
      d = 4'($urandom);
      m = 4'($urandom);
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      if (((d & ~m) | sw_model | s) == 4'b0000) s = 4'b0001 << $urandom_range(0, 3);
      set_hw(d, m, s, 1'($urandom_range(0, 1)));
      run_grant($urandom_range(0, 2), $urandom_range(1, 4),
                ($urandom_range(0, 3) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
    end

    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/dma_req_arbiter.md
# dma_req_arbiter

Parametrised N-channel DMA request arbiter and bus-hold handshake controller for the 8237A-class DMA controller. It synchronises the asynchronous peripheral DREQ lines, merges in software requests and applies per-channel masks. It selects one channel under fixed or rotating priority, runs the HRQ/HLDA hold handshake with the 8086 CPU, and drives the DACK lines for the granted channel until the transfer timing unit reports service complete.

## Interface
Parameters:
- NUM_CH, 4, number of DMA channels (2..8)
- DREQ_ACT_HIGH, 1, 1 = DREQ asserted high, 0 = asserted low
- DACK_ACT_HIGH, 0, 1 = DACK asserted high, 0 = asserted low

Ports:
- CLK  in  1  clock. One clock only.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  NUM_CH  asynchronous peripheral requests, polarity per DREQ_ACT_HIGH.
- mask_i  in  NUM_CH  1 = channel's hardware DREQ is ignored.
- sw_req_set_i  in  NUM_CH  one-cycle pulse that sets the channel's software request latch.
- rotate_i  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
- HLDA  in  1  hold acknowledge from the CPU, synchronous to CLK.
- done_i  in  1  one-cycle pulse from the timing unit: service of the granted channel is complete (transfer end or EOP).
- HRQ  out  1  hold request to the CPU.
- DACK  out  NUM_CH  one-hot acknowledge, polarity per DACK_ACT_HIGH.
- grant_valid_o  out  1  a channel is currently granted.
- grant_ch_o  out  $clog2(NUM_CH)  index of the granted channel.
- sw_req_o  out  NUM_CH  current software request latches.
- hlda_err_o  out  1  sticky: HLDA was withdrawn during GRANT.

## Operation
- DREQ passes through a 2-flop synchroniser per channel and is then normalised to active-high. pending = (sync_dreq & ~mask_i) | sw_req. Software requests ignore the mask.
- sw_req[k] is set by sw_req_set_i[k]. It is cleared on done_i while channel k is granted. If set and clear hit in the same cycle, set wins.
- prio_ptr is the index of the highest-priority channel. Search order is prio_ptr, prio_ptr+1, … modulo NUM_CH.
  - When rotate_i=0, prio_ptr is forced to 0.
  - When rotate_i=1 and done_i arrives for channel k, prio_ptr becomes (k+1) mod NUM_CH.
- State machine (IDLE, HOLD_REQ, GRANT, RELEASE):
  - IDLE: HRQ=0. If pending != 0, go to HOLD_REQ.
  - HOLD_REQ: HRQ=1.
    - If HLDA=1 and pending != 0, latch the winner into grant_ch and go to GRANT.
    - If HLDA=1 and pending == 0, go to RELEASE.
    - If HLDA=0 and pending == 0, go to IDLE.
  - GRANT: HRQ=1, grant_valid_o=1, DACK[grant_ch] asserted. The grant is never preempted: pending changes, mask changes and the requester dropping DREQ are all ignored.
    - On done_i, go to RELEASE.
    - If HLDA=0 with no done_i, set hlda_err_o, clear the grant and go to IDLE.
    - If HLDA=0 and done_i occur together, done_i takes precedence: normal completion, no error.
  - RELEASE: HRQ=0, DACK all inactive. Go to IDLE once HLDA=0, which may be the same cycle as entry.
- done_i outside GRANT is ignored.
- hlda_err_o is cleared only by RESET.

## Timing
- Reset values:
  - state = IDLE, HRQ=0, DACK all inactive (all bits = ~DACK_ACT_HIGH), grant_valid_o=0, grant_ch_o=0.
  - sw_req_o=0, hlda_err_o=0, prio_ptr=0, synchroniser flops cleared to "not requesting".
- Reset applied mid-GRANT: outputs return to reset values on the next edge, with no RELEASE state.
- All outputs are registered.
- Hardware DREQ asserted before edge 0 gives HRQ=1 after edge 2: 2 sync edges, then the IDLE→HOLD_REQ edge, i.e. 3 edges.
- sw_req_set_i pulse at edge 0 gives HRQ=1 after edge 1, because the latch is set at edge 0.
- HLDA=1 sampled at edge n gives DACK and grant_valid_o asserted after edge n.
- done_i sampled at edge m gives HRQ, DACK and grant_valid_o deasserted after edge m. prio_ptr and sw_req update at the same edge.
- After leaving RELEASE, at least one IDLE cycle separates consecutive grants, so HRQ is low for at least 2 cycles between services.

## Test plan
- Reset: hold RESET with DREQ=4'b1111 and HLDA=1 → HRQ=0, DACK=4'b1111 (active-low inactive), grant_valid_o=0, hlda_err_o=0 throughout.
- Fixed priority: DREQ=4'b1010, rotate_i=0, HLDA raised 2 cycles after HRQ → HRQ rises 3 cycles after DREQ, DACK=4'b1101 (ch1), grant_ch_o=1. After done_i → HRQ=0, and the next grant is ch1 again.
- Rotating priority: DREQ=4'b1111 held, rotate_i=1, done_i after each grant → grant sequence ch0, ch1, ch2, ch3, ch0.
- Mask and software request: mask_i=4'b0100 with DREQ[2]=1 → HRQ stays 0. Then sw_req_set_i=4'b0100 → HRQ after 1 cycle, grant ch2; done_i clears sw_req_o[2].
- Simultaneous events and error path:
  - HLDA drops while in GRANT → hlda_err_o=1, DACK inactive next cycle.
  - done_i and an HLDA drop in the same cycle → hlda_err_o stays 0.
- Vanished request: DREQ pulses, reaches HOLD_REQ, then drops before HLDA → HRQ deasserts and no DACK pulse occurs. Repeat with HLDA arriving in the same cycle the request disappears → state goes to RELEASE, no DACK pulse.
